// File: rtl/cpu_types_pkg.sv
// Shared CPU register-file types for the default 32x32 build.
package cpu_types_pkg;
  localparam int REG_COUNT     = 32;
  localparam int ZERO_REGISTER = 0;

  typedef logic [31:0]                    word_t;
  typedef logic [$clog2(REG_COUNT)-1:0]   regbits_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: flush > write clear < reserve, with r0 optionally never busy.
module rf_scoreboard #(
  parameter  int DEPTH    = 32,
  parameter  int NWRITE   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NWRITE-1:0]            clr_en,
  input  logic [NWRITE-1:0][AW-1:0]    clr_sel,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_sel,
  input  logic                         flush,
  output logic [DEPTH-1:0]             busy
);
  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int p = 0; p < NWRITE; p++)
        if (clr_en[p]) busy_nxt[clr_sel[p]] = 1'b0;
      // reserve applied last so it beats a same-cycle clear of the same register
      if (rsv_en && !((ZERO_REG != 0) && (rsv_sel == '0)))
        busy_nxt[rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) busy <= '0;
    else       busy <= busy_nxt;
endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-port register file with optional write->read bypass and busy scoreboard.
module scoreboard_register_file
  import cpu_types_pkg::*;
#(
  parameter  int DW       = 32,
  parameter  int DEPTH    = 32,
  parameter  int NREAD    = 2,
  parameter  int NWRITE   = 1,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NREAD-1:0][AW-1:0]    rsel,
  output logic [NREAD-1:0][DW-1:0]    rdat,
  output logic [NREAD-1:0]            rbusy,
  input  logic [NWRITE-1:0]           WEN,
  input  logic [NWRITE-1:0][AW-1:0]   wsel,
  input  logic [NWRITE-1:0][DW-1:0]   wdat,
  input  logic                        rsv_en,
  input  logic [AW-1:0]               rsv_sel,
  input  logic                        flush
);
  localparam logic [AW-1:0] ZSEL = AW'(ZERO_REGISTER);

  logic [DEPTH-1:0][DW-1:0] regs;
  logic [DEPTH-1:0]         busy;

  // later ports overwrite earlier ones, so the highest-index port wins
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      regs <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++)
        if (WEN[p] && !((ZERO_REG != 0) && (wsel[p] == ZSEL)))
          regs[wsel[p]] <= wdat[p];
    end

  rf_scoreboard #(
    .DEPTH   (DEPTH),
    .NWRITE  (NWRITE),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr_en (WEN),
    .clr_sel(wsel),
    .rsv_en (rsv_en),
    .rsv_sel(rsv_sel),
    .flush  (flush),
    .busy   (busy)
  );

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic          hit;
    logic [DW-1:0] fwd;

    always_comb begin
      hit = 1'b0;
      fwd = '0;
      if (BYPASS != 0)
        for (int p = 0; p < NWRITE; p++)
          if (WEN[p] && (wsel[p] == rsel[r])) begin
            hit = 1'b1;
            fwd = wdat[p];
          end
    end

    // outputs are forced low during reset so a live bypass cannot leak through
    always_comb begin
      rdat[r]  = '0;
      rbusy[r] = 1'b0;
      if (!nRST || ((ZERO_REG != 0) && (rsel[r] == ZSEL))) begin
        rdat[r]  = '0;
        rbusy[r] = 1'b0;
      end else if (hit) begin
        rdat[r]  = fwd;
        rbusy[r] = 1'b0;
      end else begin
        rdat[r]  = regs[rsel[r]];
        rbusy[r] = busy[rsel[r]];
      end
    end
  end
endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised multi-port register file for the pipelined datapath. It generalises the single-cycle file to NREAD read ports, NWRITE write ports and configurable width and depth. It adds optional write-to-read bypass and a per-register busy scoreboard, which decode uses to detect RAW hazards against in-flight writebacks. It sits between decode (read and reserve) and writeback (write and clear).

## Interface
Parameters:
- DW, 32: data width in bits.
- DEPTH, 32: number of registers (power of two). Select width AW = $clog2(DEPTH).
- NREAD, 2: number of read ports.
- NWRITE, 1: number of write ports.
- BYPASS, 1: when 1, same-cycle writes forward to reads.
- ZERO_REG, 1: when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- rsel  in  NREAD×AW  read selects.
- rdat  out  NREAD×DW  read data.
- rbusy  out  NREAD  the selected register has a pending write.
- WEN  in  NWRITE  write enables.
- wsel  in  NWRITE×AW  write selects.
- wdat  in  NWRITE×DW  write data.
- rsv_en  in  1  reserve a destination (decode issues a writer).
- rsv_sel  in  AW  register to mark busy.
- flush  in  1  clear all busy bits (pipeline squash). Data is kept.

## Operation
- Storage: DEPTH×DW array and a DEPTH-bit busy vector.
- Write: at the rising edge, for each port p with WEN[p]=1, regs[wsel[p]] <= wdat[p].
  - Writes to register 0 are dropped when ZERO_REG=1.
  - If several ports target the same register, the highest-index port wins.
- Busy update, evaluated at each edge in this priority order:
  - flush=1: busy <= 0, and rsv_en is ignored that cycle.
  - Otherwise each enabled write clears busy[wsel[p]].
  - Then rsv_en sets busy[rsv_sel]. Reserve wins over a same-cycle clear of the same register.
  - Reserve of register 0 is ignored when ZERO_REG=1.
  - Reserving a register that is already busy leaves it busy. There is no counting; decode allows at most one in-flight writer per register.
- Read, combinational, per port r:
  - ZERO_REG=1 and rsel[r]=0: rdat[r]=0 and rbusy[r]=0.
  - BYPASS=1 and some port has WEN[p] with wsel[p]=rsel[r]: rdat[r] = wdat of the highest such p, and rbusy[r]=0 (a write in flight this cycle satisfies the hazard).
  - Otherwise: rdat[r]=regs[rsel[r]] and rbusy[r]=busy[rsel[r]].
  - BYPASS=0: reads return stored values only, and rbusy is the raw busy bit.
  - rbusy does not reflect a same-cycle rsv_en.
- Reset (nRST=0, asynchronous): all registers 0, all busy 0. All rdat outputs are 0 and all rbusy outputs are 0 while reset is held.
- Reset mid-operation discards pending writes and reservations immediately, without waiting for a clock edge.

## Timing
- Read latency 0 cycles (combinational from rsel, and from WEN/wsel/wdat when BYPASS=1).
- Write latency 1 edge. Without bypass, data is visible on the cycle after the write.
- Busy set: a register reserved at edge N reads as busy from cycle N+1.
- Busy clear: busy clears at the edge of its write. With BYPASS=1, rbusy already drops during the write cycle.
- No handshake and no stalls; every input is sampled every cycle.

## Structure
- cpu_types_pkg holds word_t and regbits_t for the default DW=32 / DEPTH=32 build, plus the constants REG_COUNT=32 and ZERO_REGISTER=0. The module itself uses parameter-derived local types.
- The scoreboard becomes sub-module rf_scoreboard. It holds the busy vector plus the clear/reserve/flush priority logic, with ports CLK, nRST, the clear enables and selects, rsv_en, rsv_sel, flush, and the busy vector as output.
- The data array and forwarding mux stay in the top module, generated over NREAD/NWRITE.

## Test plan
- Reset: hold nRST=0 mid-run after writes to r5. Every rdat must be 0 and every rbusy 0 immediately, before any CLK edge; r5 must read 0 after release.
- Write/read with BYPASS=0: write r7=0xDEADBEEF at edge N. Port 0 reads the old value 0 during cycle N and 0xDEADBEEF from N+1. Writing r0=0x1234 must leave r0 reading 0.
- Bypass with BYPASS=1, NWRITE=2: ports 0 and 1 both write r3, with 0x11 and 0x22. rdat for rsel=3 must be 0x22 in the same cycle, and r3 must hold 0x22 after the edge.
- Scoreboard: rsv_en with rsv_sel=9 at edge N gives rbusy=1 for r9 from N+1. A write to r9 with 0x55 gives rbusy=0 and rdat=0x55 in the write cycle (BYPASS=1). Reserve and write of r9 in the same cycle must leave r9 busy.
- Flush: reserve r4, r8 and r12, then assert flush together with rsv_en for r4. After the edge all busy bits are 0, and data written earlier is preserved.
- Parametric: DW=64, DEPTH=16, NREAD=3, ZERO_REG=0. Write r0=0xFFFF_FFFF_FFFF_FFFF and read it on all three ports. Every rsel in 0-15 must write back and read back correctly.
